// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   DATA_W_DEF  : default word width (matches the 8-bit FIFO)
//   MAX_REQ     : largest supported requester count
//   STAT_W      : width of each per-requester accept counter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_REQ    = 8;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: purely combinational round-robin picker.
// Scans req starting at index 'start' and wrapping modulo NUM_REQ; reports the
// first set bit.
// Ports:
//   req   in  NUM_REQ  request vector
//   start in  IDX_W    index with highest priority this cycle
//   found out 1        at least one request is set
//   idx   out IDX_W    winning index (0 when found=0)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int w_pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // start < NUM_REQ and k < NUM_REQ, so one subtraction wraps the sum
      w_pos = int'(start) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      if (!found && req[IDX_W'(w_pos)]) begin
        found = 1'b1;
        idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the single FIFO write port
// among NUM_REQ producers. Each grant is a burst of at most MAX_BURST words.
// The FIFO full flag stalls the burst indefinitely.
// Optional macro FIFO_WR_ARB_STATS_EN adds per-requester saturating accept
// counters on port accept_cnt.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req         per-requester word-valid
//   req_data    flattened words, slice i = [i*DATA_W +: DATA_W]
//   gnt         one-hot accept strobe (word on slice i written this cycle)
//   fifo_full   FIFO full flag
//   write_data  FIFO write enable
//   data_input  FIFO write data
//   owner       current burst owner index
//   busy        high while in GRANT
//   accept_cnt  (stats build only) 16-bit accept counter per requester
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        fifo_full,
  output logic                        write_data,
  output logic [DATA_W-1:0]           data_input,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   accept_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       r_state, w_state_next;
  logic [IDX_W-1:0] r_owner, w_owner_next;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_next;

  logic             w_accept;
  logic             w_owner_req;
  logic [IDX_W-1:0] w_owner_inc;
  logic [IDX_W-1:0] w_pick_start;
  logic             w_pick_found;
  logic [IDX_W-1:0] w_pick_idx;

  assign w_owner_req = req[r_owner];
  assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // In GRANT the picker only matters at burst end, where the search starts
  // just past the owner so the old owner wins only if nobody else asks.
  assign w_pick_start = (r_state == GRANT) ? w_owner_inc : r_rr_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .start (w_pick_start),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_rr_ptr_next    = r_rr_ptr;
    w_burst_cnt_next = r_burst_cnt;
    w_accept         = 1'b0;
    busy             = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_next     = GRANT;
          w_owner_next     = w_pick_idx;
          w_burst_cnt_next = '0;
        end
      end
      GRANT: begin
        busy     = 1'b1;
        w_accept = w_owner_req & ~fifo_full;
        if (w_accept) begin
          w_burst_cnt_next = r_burst_cnt + 1'b1;
        end
        if ((w_accept && (r_burst_cnt == CNT_W'(MAX_BURST - 1))) || !w_owner_req) begin
          w_rr_ptr_next    = w_owner_inc;
          w_burst_cnt_next = '0;
          if (w_pick_found) begin
            w_owner_next = w_pick_idx;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Nothing may be written or advertised while reset is held, so the
    // in-flight word of an interrupted burst never reaches the FIFO.
    if (rst) begin
      w_accept = 1'b0;
      busy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_burst_cnt <= w_burst_cnt_next;
    end
  end

  assign write_data = w_accept;
  assign data_input = w_accept ? req_data[r_owner*DATA_W +: DATA_W] : '0;
  assign owner      = r_owner;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = w_accept & (r_owner == IDX_W'(gi));
    end
  endgenerate

`ifdef FIFO_WR_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [STAT_W-1:0] r_acc;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc <= '0;
        end else if (gnt[gi] && (r_acc != {STAT_W{1'b1}})) begin
          r_acc <= r_acc + 1'b1;
        end
      end
      assign accept_cnt[gi*STAT_W +: STAT_W] = r_acc;
    end
  endgenerate
`endif

endmodule
